// File: rtl/interrupt_pkg.sv
// interrupt_pkg: shared state encoding, limits and vector arithmetic for the interrupt controller
package interrupt_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam int MAX_SOURCES = 8;

    // Handler address wraps modulo 256 because rom addresses are 8 bits
    function automatic logic [7:0] vec_addr(input logic [7:0] base, input logic [7:0] stride, input logic [2:0] id);
        logic [7:0] off;
        off = stride * {5'd0, id};
        return base + off;
    endfunction
endpackage

// File: rtl/irq_priority_encoder.sv
// irq_priority_encoder: lowest-index set bit of the candidate vector
module irq_priority_encoder #(
    parameter int N = 4
) (
    input  logic [N-1:0] cand,
    output logic [2:0]   id,
    output logic         valid
);
    // Scan from the top so the lowest set index is written last and wins
    always_comb begin
        id = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) begin
                id = 3'(i);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-detected, masked, prioritised interrupt dispatch to the rom jump path
module interrupt_controller
    import interrupt_pkg::*;
#(
    parameter int         NUM_SOURCES   = 4,
    parameter logic [7:0] VECTOR_BASE   = 8'hF0,
    parameter int         VECTOR_STRIDE = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SOURCES-1:0] irq,
    input  logic                   mask_w_enable,
    input  logic [NUM_SOURCES-1:0] mask_w_data,
    input  logic                   global_w_enable,
    input  logic                   global_w_data,
    input  logic                   ack,
    input  logic                   reti,
    output logic                   jump,
    output logic [7:0]             vector,
    output logic                   status,
    output logic [2:0]             active_id,
    output logic [NUM_SOURCES-1:0] pending,
    output logic [NUM_SOURCES-1:0] mask
);
    state_t                 state, state_next;
    logic [NUM_SOURCES-1:0] irq_q, clr;
    logic                   global_en, win_valid, dispatch, take, done;
    logic [2:0]             win_id;

    irq_priority_encoder #(.N(NUM_SOURCES)) u_enc (
        .cand  (pending & mask),
        .id    (win_id),
        .valid (win_valid)
    );

    // Next-state logic; dispatch/take/done mark the edges that move the registered outputs
    always_comb begin
        state_next = state;
        dispatch = 1'b0;
        take = 1'b0;
        done = 1'b0;
        case (state)
            IDLE:    if (global_en && win_valid) begin dispatch = 1'b1; state_next = REQUEST; end
            REQUEST: if (ack) begin take = 1'b1; state_next = SERVICE; end
            SERVICE: if (reti) begin done = 1'b1; state_next = IDLE; end
            default: state_next = IDLE;
        endcase
    end

    assign clr = take ? (NUM_SOURCES'(1) << active_id) : '0;

    // State, configuration and registered outputs; a new edge beats a same-cycle clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            irq_q     <= '0;
            pending   <= '0;
            mask      <= '0;
            global_en <= 1'b0;
            jump      <= 1'b0;
            vector    <= '0;
            status    <= 1'b0;
            active_id <= '0;
        end else begin
            state     <= state_next;
            irq_q     <= irq;
            pending   <= (pending & ~clr) | (irq & ~irq_q);
            mask      <= mask_w_enable ? mask_w_data : mask;
            global_en <= global_w_enable ? global_w_data : global_en;
            jump      <= dispatch ? 1'b1 : (take ? 1'b0 : jump);
            vector    <= dispatch ? vec_addr(VECTOR_BASE, 8'(VECTOR_STRIDE), win_id) : vector;
            active_id <= dispatch ? win_id : active_id;
            status    <= take ? 1'b1 : (done ? 1'b0 : status);
        end
    end
endmodule
